// File: rtl/a_all_frame_er_ctrl.sv
// a_all_frame_er_ctrl: sequences error verification over every frame.
// For each frame it sends a header word to Bob, hands the FIFOs to the
// single-frame ER engine, sends an end word carrying the local result,
// then waits for Bob's acknowledgement and folds both results into
// fail_count. Any bad or missing acknowledgement aborts the whole run.
module a_all_frame_er_ctrl #(
  parameter int MAX_FRAME_ROUND   = 7,
  parameter int FRAME_ROUND_WIDTH = 8,
  parameter int ACK_TIMEOUT       = 65535
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start_A_all_frame_ER,
  input  logic                         finish_A_single_frame_ER,
  input  logic                         single_frame_ev_fail,
  output logic                         start_single_frame_ER,
  output logic [FRAME_ROUND_WIDTH-1:0] frame_round,
  output logic                         ctrl_owns_fifo,
  output logic [31:0]                  A_A2B_wr_din,
  output logic                         A_A2B_wr_en,
  input  logic                         A_A2B_full,
  output logic                         A_B2A_rd_en,
  input  logic [31:0]                  A_B2A_rd_dout,
  input  logic                         A_B2A_empty,
  input  logic                         A_B2A_rd_valid,
  output logic [FRAME_ROUND_WIDTH:0]   fail_count,
  output logic                         timeout_error,
  output logic                         protocol_error,
  output logic                         finish_all_frame_ER,
  output logic                         busy
);

  // Timer only has to count 0..ACK_TIMEOUT-1 before giving up.
  localparam int TW = (ACK_TIMEOUT > 2) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(ACK_TIMEOUT - 1);
  localparam logic [FRAME_ROUND_WIDTH-1:0] LAST_FRAME = FRAME_ROUND_WIDTH'(MAX_FRAME_ROUND);

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_START_AF,
    ST_SEND_HDR,
    ST_START_SF,
    ST_SF_BUSY,
    ST_SEND_END,
    ST_WAIT_ACK,
    ST_CHECK_ACK,
    ST_NEXT_FRAME,
    ST_RESET_AF,
    ST_AF_END,
    ST_ERROR
  } state_t;

  state_t state_reg, state_next;

  logic [FRAME_ROUND_WIDTH-1:0] frame_round_reg;
  logic [FRAME_ROUND_WIDTH:0]   fail_count_reg;
  logic                         timeout_error_reg;
  logic                         protocol_error_reg;
  logic                         loc_fail_reg;
  logic                         rd_outst_reg;
  logic [TW-1:0]                tmo_cnt_reg;
  logic [7:0]                   ack_tag_reg;
  logic                         ack_bob_reg;
  logic [15:0]                  ack_frame_reg;

  logic [15:0] frame16;
  logic        ack_ok;
  logic        ack_fire;
  logic        tmo_hit;
  logic        unused_ack_bits;

  // Ack bits 23:17 carry nothing for this block.
  assign unused_ack_bits = ^A_B2A_rd_dout[23:17];

  assign frame16  = 16'(frame_round_reg);
  assign ack_ok   = (ack_tag_reg == 8'hBE) && (ack_frame_reg == frame16);
  // Only a rd_valid answering our own outstanding read counts as the ack.
  assign ack_fire = A_B2A_rd_valid && rd_outst_reg;
  assign tmo_hit  = (tmo_cnt_reg == TMO_LAST);

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic and per-state FIFO / handshake outputs.
  always_comb begin
    state_next            = state_reg;
    start_single_frame_ER = 1'b0;
    A_A2B_wr_en           = 1'b0;
    A_A2B_wr_din          = 32'h0;
    A_B2A_rd_en           = 1'b0;
    finish_all_frame_ER   = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (start_A_all_frame_ER) state_next = ST_START_AF;
      end
      ST_START_AF: state_next = ST_SEND_HDR;
      ST_SEND_HDR: begin
        if (!A_A2B_full) begin
          A_A2B_wr_en  = 1'b1;
          A_A2B_wr_din = {8'hA5, 8'h00, frame16};
          state_next   = ST_START_SF;
        end
      end
      ST_START_SF: begin
        start_single_frame_ER = 1'b1;
        state_next            = ST_SF_BUSY;
      end
      ST_SF_BUSY: begin
        if (finish_A_single_frame_ER) state_next = ST_SEND_END;
      end
      ST_SEND_END: begin
        if (!A_A2B_full) begin
          A_A2B_wr_en  = 1'b1;
          A_A2B_wr_din = {8'hAE, 7'b0, loc_fail_reg, frame16};
          state_next   = ST_WAIT_ACK;
        end
      end
      ST_WAIT_ACK: begin
        A_B2A_rd_en = !A_B2A_empty && !rd_outst_reg;
        if (ack_fire) begin
          state_next = ST_CHECK_ACK;
        end else if (tmo_hit) begin
          state_next = ST_ERROR;
        end
      end
      ST_CHECK_ACK: begin
        if (!ack_ok) begin
          state_next = ST_ERROR;
        end else if (frame_round_reg == LAST_FRAME) begin
          state_next = ST_RESET_AF;
        end else begin
          state_next = ST_NEXT_FRAME;
        end
      end
      ST_NEXT_FRAME: state_next = ST_SEND_HDR;
      ST_RESET_AF:   state_next = ST_AF_END;
      ST_AF_END: begin
        finish_all_frame_ER = 1'b1;
        state_next          = ST_IDLE;
      end
      ST_ERROR: begin
        finish_all_frame_ER = 1'b1;
        state_next          = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Frame counter, result accumulation and sticky error flags.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      frame_round_reg    <= '0;
      fail_count_reg     <= '0;
      timeout_error_reg  <= 1'b0;
      protocol_error_reg <= 1'b0;
      loc_fail_reg       <= 1'b0;
    end else begin
      case (state_reg)
        ST_START_AF: begin
          frame_round_reg    <= '0;
          fail_count_reg     <= '0;
          timeout_error_reg  <= 1'b0;
          protocol_error_reg <= 1'b0;
        end
        ST_SF_BUSY: begin
          if (finish_A_single_frame_ER) loc_fail_reg <= single_frame_ev_fail;
        end
        ST_WAIT_ACK: begin
          if (!ack_fire && tmo_hit) timeout_error_reg <= 1'b1;
        end
        ST_CHECK_ACK: begin
          if (!ack_ok) begin
            protocol_error_reg <= 1'b1;
          end else if ((loc_fail_reg || ack_bob_reg) && !(&fail_count_reg)) begin
            fail_count_reg <= fail_count_reg + (FRAME_ROUND_WIDTH + 1)'(1);
          end
        end
        ST_NEXT_FRAME: frame_round_reg <= frame_round_reg + FRAME_ROUND_WIDTH'(1);
        ST_RESET_AF:   frame_round_reg <= '0;
        default: ;
      endcase
    end
  end

  // Ack read tracking: timer and outstanding flag restart on every WAIT_ACK entry.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tmo_cnt_reg   <= '0;
      rd_outst_reg  <= 1'b0;
      ack_tag_reg   <= 8'h00;
      ack_bob_reg   <= 1'b0;
      ack_frame_reg <= 16'h0;
    end else if (state_reg == ST_WAIT_ACK) begin
      tmo_cnt_reg <= tmo_cnt_reg + TW'(1);
      if (A_B2A_rd_en) rd_outst_reg <= 1'b1;
      if (ack_fire) begin
        rd_outst_reg  <= 1'b0;
        ack_tag_reg   <= A_B2A_rd_dout[31:24];
        ack_bob_reg   <= A_B2A_rd_dout[16];
        ack_frame_reg <= A_B2A_rd_dout[15:0];
      end
    end else begin
      tmo_cnt_reg  <= '0;
      rd_outst_reg <= 1'b0;
    end
  end

  assign frame_round    = frame_round_reg;
  assign fail_count     = fail_count_reg;
  assign timeout_error  = timeout_error_reg;
  assign protocol_error = protocol_error_reg;
  assign busy           = (state_reg != ST_IDLE);
  assign ctrl_owns_fifo = !((state_reg == ST_START_SF) || (state_reg == ST_SF_BUSY));

endmodule

// File: tb/tb_a_all_frame_er_ctrl.sv
// tb_a_all_frame_er_ctrl: randomized scoreboard bench. The stimulus side
// plans each run frame by frame, derives the expected A2B words and the
// final status from that plan, and queues them; an environment process
// plays the single-frame ER engine, the FIFOs and Bob; a monitor pops the
// queues whenever the DUT writes a word or signals completion.
module tb_a_all_frame_er_ctrl;

  localparam int MAXF = 2;
  localparam int FRW  = 8;
  localparam int TMO  = 16;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           start_A_all_frame_ER;
  logic           finish_A_single_frame_ER;
  logic           single_frame_ev_fail;
  logic           start_single_frame_ER;
  logic [FRW-1:0] frame_round;
  logic           ctrl_owns_fifo;
  logic [31:0]    A_A2B_wr_din;
  logic           A_A2B_wr_en;
  logic           A_A2B_full;
  logic           A_B2A_rd_en;
  logic [31:0]    A_B2A_rd_dout;
  logic           A_B2A_empty;
  logic           A_B2A_rd_valid;
  logic [FRW:0]   fail_count;
  logic           timeout_error;
  logic           protocol_error;
  logic           finish_all_frame_ER;
  logic           busy;

  always #5 clk = ~clk;

  a_all_frame_er_ctrl #(
    .MAX_FRAME_ROUND(MAXF),
    .FRAME_ROUND_WIDTH(FRW),
    .ACK_TIMEOUT(TMO)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start_A_all_frame_ER(start_A_all_frame_ER),
    .finish_A_single_frame_ER(finish_A_single_frame_ER),
    .single_frame_ev_fail(single_frame_ev_fail),
    .start_single_frame_ER(start_single_frame_ER),
    .frame_round(frame_round),
    .ctrl_owns_fifo(ctrl_owns_fifo),
    .A_A2B_wr_din(A_A2B_wr_din),
    .A_A2B_wr_en(A_A2B_wr_en),
    .A_A2B_full(A_A2B_full),
    .A_B2A_rd_en(A_B2A_rd_en),
    .A_B2A_rd_dout(A_B2A_rd_dout),
    .A_B2A_empty(A_B2A_empty),
    .A_B2A_rd_valid(A_B2A_rd_valid),
    .fail_count(fail_count),
    .timeout_error(timeout_error),
    .protocol_error(protocol_error),
    .finish_all_frame_ER(finish_all_frame_ER),
    .busy(busy)
  );

  typedef struct {int fc; bit te; bit pe; int n; int gap;} fin_t;
  typedef struct {bit none; logic [31:0] w;} ack_t;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_wr_q[$];
  fin_t        exp_fin_q[$];
  bit          sf_plan_q[$];
  ack_t        ack_plan_q[$];
  logic [31:0] b2a_q[$];

  bit full_force   = 1'b0;
  int sf_min_delay = 0;

  // per-frame plan of the next run
  bit          plan_loc  [0:MAXF];
  bit          plan_bob  [0:MAXF];
  int          plan_kind [0:MAXF];   // 0 good ack, 1 bad ack, 2 no ack
  logic [31:0] plan_badw [0:MAXF];
  logic [6:0]  plan_junk [0:MAXF];

  int cyc = 0, starts_run = 0, last_ae_cyc = 0, done_cnt = 0, exp_done = 0;
  bit busy_chk = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- environment: SF engine, FIFOs, Bob ----------------
  bit          e_seen_start, e_seen_ae, e_seen_rd;
  bit          e_sf_pend, e_sf_val, e_bob_has;
  int          e_sf_wait, e_bob_wait;
  logic [31:0] e_bob_w;
  ack_t        e_ack;

  initial begin
    A_A2B_full = 1'b0; finish_A_single_frame_ER = 1'b0; single_frame_ev_fail = 1'b0;
    A_B2A_empty = 1'b1; A_B2A_rd_valid = 1'b0; A_B2A_rd_dout = 32'h0;
    e_sf_pend = 1'b0; e_bob_has = 1'b0;
    forever begin
      @(negedge clk);
      e_seen_start = (start_single_frame_ER === 1'b1);
      e_seen_ae    = (A_A2B_wr_en === 1'b1) && (A_A2B_wr_din[31:24] == 8'hAE);
      e_seen_rd    = (A_B2A_rd_en === 1'b1);
      @(posedge clk);
      #1;
      if (!rst_n) begin
        e_sf_pend = 1'b0; e_bob_has = 1'b0; b2a_q.delete();
        A_A2B_full = 1'b0; finish_A_single_frame_ER = 1'b0;
        A_B2A_rd_valid = 1'b0; A_B2A_empty = 1'b1;
        continue;
      end
      if (e_seen_start) begin
        e_sf_pend = 1'b1;
        e_sf_wait = sf_min_delay + int'($urandom % 4);
        e_sf_val  = (sf_plan_q.size() > 0) ? sf_plan_q.pop_front() : 1'b0;
      end
      finish_A_single_frame_ER = 1'b0;
      single_frame_ev_fail     = 1'($urandom % 2);
      if (e_sf_pend) begin
        if (e_sf_wait == 0) begin
          finish_A_single_frame_ER = 1'b1;
          single_frame_ev_fail     = e_sf_val;
          e_sf_pend                = 1'b0;
        end else begin
          e_sf_wait--;
        end
      end else if ($urandom % 8 == 0) begin
        finish_A_single_frame_ER = 1'b1;   // stray pulse, must be ignored
      end
      if (e_seen_ae && ack_plan_q.size() > 0) begin
        e_ack = ack_plan_q.pop_front();
        if (!e_ack.none) begin
          e_bob_has = 1'b1; e_bob_wait = int'($urandom % 4); e_bob_w = e_ack.w;
        end
      end
      if (e_bob_has) begin
        if (e_bob_wait == 0) begin
          b2a_q.push_back(e_bob_w);
          e_bob_has = 1'b0;
        end else begin
          e_bob_wait--;
        end
      end
      A_B2A_rd_valid = 1'b0;
      A_B2A_rd_dout  = $urandom;
      if (e_seen_rd) begin
        if (b2a_q.size() > 0) A_B2A_rd_dout = b2a_q.pop_front();
        A_B2A_rd_valid = 1'b1;
      end
      A_B2A_empty = (b2a_q.size() == 0);
      A_A2B_full  = full_force || ($urandom % 4 == 0);
    end
  end

  // ---------------- monitor / scoreboard ----------------
  fin_t m_f;
  logic [31:0] m_w;

  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (rst_n !== 1'b1) begin
        starts_run = 0; busy_chk = 1'b0;
        continue;
      end
      if (busy_chk) begin
        chk("busy_after_finish", 32'(busy), 32'd0);
        busy_chk = 1'b0;
      end
      if (start_single_frame_ER) begin
        chk("owns_fifo_in_start_sf", 32'(ctrl_owns_fifo), 32'd0);
        chk("frame_round_at_start", 32'(frame_round), 32'(starts_run));
        starts_run++;
      end
      if (A_A2B_wr_en) begin
        chk("wr_en_while_full", 32'(A_A2B_full), 32'd0);
        chk("owns_fifo_on_write", 32'(ctrl_owns_fifo), 32'd1);
        if (exp_wr_q.size() == 0) begin
          chk("unexpected_a2b_write", A_A2B_wr_din, 32'hxxxxxxxx);
        end else begin
          m_w = exp_wr_q.pop_front();
          chk("a2b_word", A_A2B_wr_din, m_w);
        end
        if (A_A2B_wr_din[31:24] == 8'hAE) last_ae_cyc = cyc;
      end
      if (A_B2A_rd_en) chk("rd_en_while_empty", 32'(A_B2A_empty), 32'd0);
      if (finish_all_frame_ER) begin
        if (exp_fin_q.size() == 0) begin
          chk("unexpected_finish", 32'd1, 32'd0);
        end else begin
          m_f = exp_fin_q.pop_front();
          chk("fail_count", 32'(fail_count), 32'(m_f.fc));
          chk("timeout_error", 32'(timeout_error), 32'(m_f.te));
          chk("protocol_error", 32'(protocol_error), 32'(m_f.pe));
          chk("sf_start_count", 32'(starts_run), 32'(m_f.n));
          if (m_f.gap != 0) chk("timeout_latency", 32'(cyc - last_ae_cyc), 32'(m_f.gap));
          $display("run %0d done: frames=%0d fail_count=%0d timeout=%0b protocol=%0b",
                   done_cnt, starts_run, fail_count, timeout_error, protocol_error);
        end
        busy_chk   = 1'b1;
        starts_run = 0;
        done_cnt++;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic plan_clear();
    for (int i = 0; i <= MAXF; i++) begin
      plan_loc[i] = 1'b0; plan_bob[i] = 1'b0; plan_kind[i] = 0;
      plan_badw[i] = 32'h0; plan_junk[i] = 7'h0;
    end
  endtask

  task automatic check_reset_vals();
    chk("rst_frame_round", 32'(frame_round), 32'd0);
    chk("rst_fail_count", 32'(fail_count), 32'd0);
    chk("rst_timeout_error", 32'(timeout_error), 32'd0);
    chk("rst_protocol_error", 32'(protocol_error), 32'd0);
    chk("rst_start_sf", 32'(start_single_frame_ER), 32'd0);
    chk("rst_finish", 32'(finish_all_frame_ER), 32'd0);
    chk("rst_wr_en", 32'(A_A2B_wr_en), 32'd0);
    chk("rst_rd_en", 32'(A_B2A_rd_en), 32'd0);
    chk("rst_wr_din", A_A2B_wr_din, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_owns_fifo", 32'(ctrl_owns_fifo), 32'd1);
  endtask

  task automatic wait_done(input int target);
    int k = 0;
    while (done_cnt < target && k < 4000) begin
      @(posedge clk);
      k++;
    end
    chk("run_completed", 32'(done_cnt), 32'(target));
  endtask

  // Reference model: walk the plan frame by frame until a bad/missing ack.
  task automatic do_run(input bit immediate, input bit hold_full, input bit extra_start);
    fin_t f;
    ack_t a;
    f = '{fc: 0, te: 1'b0, pe: 1'b0, n: 0, gap: 0};
    for (int i = 0; i <= MAXF; i++) begin
      exp_wr_q.push_back(32'hA5000000 + 32'(i));
      exp_wr_q.push_back(32'hAE000000 + (plan_loc[i] ? 32'h10000 : 32'h0) + 32'(i));
      sf_plan_q.push_back(plan_loc[i]);
      f.n++;
      a.none = 1'b0;
      a.w    = 32'h0;
      if (plan_kind[i] == 0) begin
        a.w = 32'hBE000000 + (32'(plan_junk[i]) << 17) + (plan_bob[i] ? 32'h10000 : 32'h0) + 32'(i);
        if (plan_loc[i] || plan_bob[i]) f.fc++;
      end else if (plan_kind[i] == 1) begin
        a.w  = plan_badw[i];
        f.pe = 1'b1;
      end else begin
        a.none = 1'b1;
        f.te   = 1'b1;
        f.gap  = TMO + 1;
      end
      ack_plan_q.push_back(a);
      if (plan_kind[i] != 0) break;
    end
    exp_fin_q.push_back(f);
    exp_done++;
    if (!immediate) begin
      @(posedge clk);
      #2;
    end
    start_A_all_frame_ER = 1'b1;
    if (hold_full) full_force = 1'b1;
    @(posedge clk);
    #2;
    start_A_all_frame_ER = 1'b0;
    if (hold_full) begin
      repeat (11) @(posedge clk);
      #2;
      full_force = 1'b0;
    end
    if (extra_start) begin
      repeat (3) @(posedge clk);
      #2;
      start_A_all_frame_ER = 1'b1;
      @(posedge clk);
      #2;
      start_A_all_frame_ER = 1'b0;
    end
    wait_done(exp_done);
    chk("a2b_words_left", 32'(exp_wr_q.size()), 32'd0);
  endtask

  initial begin
    int k;
    int r;
    rst_n = 1'b0;
    start_A_all_frame_ER = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_vals();
    @(posedge clk);
    #2;
    rst_n = 1'b1;

    // all frames clean, start on the first cycle out of reset
    plan_clear();
    do_run(1'b1, 1'b0, 1'b0);

    // local fail on frame 0, Bob clean; later frames still run
    plan_clear();
    plan_loc[0] = 1'b1;
    do_run(1'b0, 1'b0, 1'b0);

    // A2B full held across the header slot; Bob fail on last frame
    plan_clear();
    plan_bob[MAXF] = 1'b1;
    do_run(1'b0, 1'b1, 1'b0);

    // wrong frame index in the frame-0 ack
    plan_clear();
    plan_kind[0] = 1; plan_badw[0] = 32'hBE000005;
    do_run(1'b0, 1'b0, 1'b0);

    // no ack on frame 1
    plan_clear();
    plan_loc[0] = 1'b1; plan_kind[1] = 2;
    do_run(1'b0, 1'b0, 1'b0);

    // reset while frame 1 is inside the single-frame engine
    plan_clear();
    exp_wr_q.push_back(32'hA5000000);
    exp_wr_q.push_back(32'hAE010000);
    exp_wr_q.push_back(32'hA5000001);
    sf_plan_q.push_back(1'b1);
    sf_plan_q.push_back(1'b0);
    ack_plan_q.push_back('{none: 1'b0, w: 32'hBE000000});
    sf_min_delay = 30;
    @(posedge clk);
    #2;
    start_A_all_frame_ER = 1'b1;
    @(posedge clk);
    #2;
    start_A_all_frame_ER = 1'b0;
    k = 0;
    while (starts_run < 2 && k < 2000) begin
      @(posedge clk);
      k++;
    end
    chk("reached_frame1_sf", 32'(starts_run), 32'd2);
    @(negedge clk);
    chk("fail_count_before_reset", 32'(fail_count), 32'd1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_vals();
    chk("a2b_words_before_reset", 32'(exp_wr_q.size()), 32'd0);
    sf_plan_q.delete();
    ack_plan_q.delete();
    exp_wr_q.delete();
    sf_min_delay = 0;
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    plan_clear();
    do_run(1'b0, 1'b0, 1'b0);

    // randomized runs
    for (int n = 0; n < 20; n++) begin
      plan_clear();
      for (int i = 0; i <= MAXF; i++) begin
        plan_loc[i]  = 1'($urandom % 2);
        plan_bob[i]  = 1'($urandom % 2);
        plan_junk[i] = 7'($urandom);
        r = int'($urandom % 100);
        plan_kind[i] = (r < 10) ? 1 : ((r < 20) ? 2 : 0);
        if ($urandom % 2 == 0) begin
          plan_badw[i] = 32'hBE000000 + 32'(i + 1 + int'($urandom % 5));
        end else begin
          plan_badw[i] = {8'($urandom % 190), 8'($urandom), 16'(i)};
        end
      end
      do_run(1'b0, ($urandom % 4 == 0), ($urandom % 2 == 0));
    end

    repeat (5) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
